bt_debounce_multi: RTL and testbench
====================================

Name: bt_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner: successor to the single-channel debouncer.
- Per channel: synchronises the raw pin, debounces with a symmetric stability counter, exports the clean level, and emits one-cycle event pulses for press, release, long-press and auto-repeat.
- Sits between board buttons and the control/menu logic (play, next, volume up/down), so consumers need no edge detection of their own.

Parameters:
- CHANNELS, 4, number of independent button channels.
- CNT_W, 32, width of the debounce and hold counters; must hold max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC).
- DEBOUNCE_CYC, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYC, 50000000, cycles of held level before bt_long fires; minimum 2.
- REPEAT_CYC, 10000000, period of bt_repeat after bt_long; minimum 2.
- ACTIVE_LOW, 1, 1 = pressed reads 0 on the pin; 0 = pressed reads 1.
- REPEAT_EN, 1, 1 enables bt_repeat; 0 forces bt_repeat to 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bt  input  CHANNELS  raw asynchronous button pins.
- bt_level  output  CHANNELS  debounced level, 1 = pressed.
- bt_press  output  CHANNELS  one-cycle pulse on accepted press.
- bt_release  output  CHANNELS  one-cycle pulse on accepted release.
- bt_long  output  CHANNELS  one-cycle pulse when held LONG_CYC cycles.
- bt_repeat  output  CHANNELS  one-cycle pulse every REPEAT_CYC cycles after bt_long while held.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: every output is 0. Synchroniser flops reset to the inactive pin level (1 if ACTIVE_LOW). All counters are 0 and every FSM is IDLE.
- Synchroniser: 2-FF per channel, then normalised to act = sync ^ ACTIVE_LOW.
- Debounce counter, per channel:
  - If act == bt_level, the counter clears.
  - Otherwise it increments.
  - On the DEBOUNCE_CYC-th consecutive disagreeing cycle, bt_level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles has no effect. Bounce restarts the count.
- Latency: bt_level changes DEBOUNCE_CYC+1 edges after the first edge that samples the new pin value.
- Press/release pulses: bt_press is high for exactly the first cycle in which bt_level is 1. bt_release is high for exactly the first cycle in which bt_level is 0. Both are registered, so there is no combinational path from bt.
- Hold FSM, per channel, with states IDLE, DOWN and LONG:
  - IDLE -> DOWN on press. The hold counter is 1 in the bt_press cycle.
  - DOWN: the counter increments each cycle. When it reaches LONG_CYC, assert bt_long for that cycle, go to LONG and load the counter with 1.
  - LONG: the counter increments. When it reaches REPEAT_CYC, assert bt_repeat (if REPEAT_EN) and reload with 1.
  - Any state -> IDLE in the bt_release cycle. bt_long and bt_repeat are never asserted in or after the release cycle.
- Timing consequence: bt_long comes LONG_CYC-1 cycles after bt_press. The repeats follow at +REPEAT_CYC intervals.
- Channels are fully independent. Simultaneous events on several channels assert their pulses in the same cycle.
- Reset mid-operation: outputs drop at once. No release pulse is generated for a button that was pressed.
  - A button still held when reset ends is treated as a new press.
  - It yields bt_press after the normal debounce latency, then the normal long/repeat sequence.
- Counters saturate rather than wrap. No counter can exceed its threshold.

Test Plan:
Common setup: CHANNELS=2, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, ACTIVE_LOW=1, REPEAT_EN=1.
1. Clean press: bt[0] 1->0 and held -> bt_level[0] rises at sample edge+5; bt_press[0]=1 for that one cycle only; bt[1] channel outputs stay 0.
2. Glitch and bounce: bt[0] low for 3 cycles, then high -> no level change, no pulses. Pattern 0,1,0,1 then steady 0 -> exactly one bt_press, at 5 edges after the last transition's sample.
3. Long hold: press, hold 40 cycles after bt_press -> bt_long at bt_press+19, bt_repeat at +27 and +35. Then release -> one bt_release, no further repeat. With REPEAT_EN=0 -> bt_repeat never asserts.
4. Short hold: press, release 10 cycles later -> bt_press and bt_release each exactly once; no bt_long.
5. Simultaneous: bt[1:0]=00 at the same edge -> bt_press=11 in the same cycle. Release only ch1 -> bt_release=10, and ch0 still gets bt_long.
6. Reset mid-hold: assert rst_n=0 while ch0 is in LONG -> all outputs 0 immediately. Release reset with the button still held -> bt_press[0] at sample edge+5, no bt_release emitted for the interrupted press.

Source files
------------

// File: rtl/bt_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, symmetric debounce, and
// registered press/release/long/repeat pulses per channel.

module bt_debounce_lane #(
  parameter int CNT_W        = 32,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o,
  output logic rpt_o
);
  localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);
  localparam logic             RPT_ON   = (REPEAT_EN != 0);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_LONG} hold_t;

  logic             sync1_q, sync2_q, act;
  logic             level_q, level_d, toggle, press_ev, rel_ev;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
  logic             press_q, rel_q, long_q, long_d, rpt_q, rpt_d;
  hold_t            state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  assign act = sync2_q ^ PIN_IDLE;

  // Any agreement with the accepted level restarts the stability count.
  always_comb begin
    dcnt_d = '0;
    toggle = 1'b0;
    if (act != level_q) begin
      if (dcnt_q >= DEB_LAST) toggle = 1'b1;
      else                    dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  assign level_d  = level_q ^ toggle;
  assign press_ev = toggle & ~level_q;
  assign rel_ev   = toggle & level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rel_ev) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (press_ev) state_d = S_DOWN;
        S_DOWN:  if (hcnt_q >= LNG_LAST) state_d = S_LONG;
        default: ;
      endcase
    end
  end

  // Counter holds 0 in the pulse cycle so it reads 1 on the cycle after.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    rpt_d  = 1'b0;
    if (!rel_ev) begin
      case (state_q)
        S_IDLE: if (press_ev) hcnt_d = CNT_W'(1);
        S_DOWN: begin
          if (hcnt_q >= LNG_LAST) long_d = 1'b1;
          else                    hcnt_d = hcnt_q + CNT_W'(1);
        end
        S_LONG: begin
          if (hcnt_q >= RPT_LAST) rpt_d  = RPT_ON;
          else                    hcnt_d = hcnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      press_q <= press_ev;
      rel_q   <= rel_ev;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign long_o  = long_q;
  assign rpt_o   = rpt_q;
endmodule

module bt_debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 32,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_EN    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] bt,
  output logic [CHANNELS-1:0] bt_level,
  output logic [CHANNELS-1:0] bt_press,
  output logic [CHANNELS-1:0] bt_release,
  output logic [CHANNELS-1:0] bt_long,
  output logic [CHANNELS-1:0] bt_repeat
);
  bt_debounce_lane #(
    .CNT_W(CNT_W), .DEBOUNCE_CYC(DEBOUNCE_CYC), .LONG_CYC(LONG_CYC),
    .REPEAT_CYC(REPEAT_CYC), .ACTIVE_LOW(ACTIVE_LOW), .REPEAT_EN(REPEAT_EN)
  ) u_lane [CHANNELS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin     (bt),
    .level_o (bt_level),
    .press_o (bt_press),
    .rel_o   (bt_release),
    .long_o  (bt_long),
    .rpt_o   (bt_repeat)
  );
endmodule

// File: tb/tb_bt_debounce_multi.sv
// Scoreboard bench for bt_debounce_multi: a pin-history model queues expected
// pulse cycles, a negedge monitor pops and compares against two DUT configs.

module tb_bt_debounce_multi;
  localparam int CH = 2, CW = 8, DEB = 4, LNG = 20, RPT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] bt = '1;
  logic [CH-1:0] bt_n;
  logic [CH-1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
  logic [CH-1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;

  assign bt_n = ~bt;

  always #5 clk = ~clk;

  bt_debounce_multi #(.CHANNELS(CH), .CNT_W(CW), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG),
    .REPEAT_CYC(RPT), .ACTIVE_LOW(1), .REPEAT_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bt(bt), .bt_level(lvl_a), .bt_press(prs_a),
    .bt_release(rel_a), .bt_long(lng_a), .bt_repeat(rpt_a));

  bt_debounce_multi #(.CHANNELS(CH), .CNT_W(CW), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG),
    .REPEAT_CYC(RPT), .ACTIVE_LOW(0), .REPEAT_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bt(bt_n), .bt_level(lvl_b), .bt_press(prs_b),
    .bt_release(rel_b), .bt_long(lng_b), .bt_repeat(rpt_b));

  typedef struct {
    int            cyc;
    logic [CH-1:0] lvl, prs, rel, lng, rpt;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0, fails = 0;
  int            cyc = 0, base = 0;
  logic [CH-1:0] hist [0:16383];
  logic [CH-1:0] mlev = '0;
  int            ptime [CH];

  // Pressed-ness of the pin as sampled at edge idx; nothing before reset counts.
  function automatic logic act_at(input int ch, input int idx);
    if (idx < base) return 1'b0;
    return ~hist[idx][ch];
  endfunction

  // Reference: level flips once the pin has read the opposite level on DEB
  // consecutive sampled edges (seen two edges later through the synchroniser);
  // long/repeat follow from elapsed time since the press.
  initial begin : model
    exp_t e;
    logic flip;
    int   d;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        base = cyc + 1;
        mlev = '0;
      end else begin
        hist[cyc] = bt;
        e.cyc = cyc; e.prs = '0; e.rel = '0; e.lng = '0; e.rpt = '0;
        for (int ch = 0; ch < CH; ch++) begin
          flip = 1'b1;
          for (int k = 2; k <= DEB + 1; k++)
            if (act_at(ch, cyc - k) == mlev[ch]) flip = 1'b0;
          if (flip) begin
            if (!mlev[ch]) begin e.prs[ch] = 1'b1; ptime[ch] = cyc; end
            else           e.rel[ch] = 1'b1;
            mlev[ch] = ~mlev[ch];
          end else if (mlev[ch]) begin
            d = cyc - ptime[ch];
            if (d == LNG - 1) e.lng[ch] = 1'b1;
            else if (d > LNG - 1 && ((d - (LNG - 1)) % RPT) == 0) e.rpt[ch] = 1'b1;
          end
        end
        e.lvl = mlev;
        if (|{e.prs, e.rel, e.lng, e.rpt}) sb.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      tests++;
      if (lvl_a !== mlev || lvl_b !== mlev) begin
        fails++;
        $display("FAIL level cyc=%0d got a=%b b=%b want=%b", cyc, lvl_a, lvl_b, mlev);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missed_pulse cyc=%0d want prs=%b rel=%b lng=%b rpt=%b",
                 sb[0].cyc, sb[0].prs, sb[0].rel, sb[0].lng, sb[0].rpt);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        tests++;
        if ({prs_a, rel_a, lng_a, rpt_a} !== {e.prs, e.rel, e.lng, e.rpt} ||
            {prs_b, rel_b, lng_b, rpt_b} !== {e.prs, e.rel, e.lng, {CH{1'b0}}}) begin
          fails++;
          $display("FAIL pulses cyc=%0d got a=%b b=%b want prs/rel/lng/rpt=%b (b rpt=0)",
                   cyc, {prs_a, rel_a, lng_a, rpt_a}, {prs_b, rel_b, lng_b, rpt_b},
                   {e.prs, e.rel, e.lng, e.rpt});
        end
      end else if (|{prs_a, rel_a, lng_a, rpt_a, prs_b, rel_b, lng_b, rpt_b}) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse cyc=%0d got a=%b b=%b want 0", cyc,
                 {prs_a, rel_a, lng_a, rpt_a}, {prs_b, rel_b, lng_b, rpt_b});
      end
    end
  end

  task automatic hold(input logic [CH-1:0] v, input int n);
    bt = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (|{lvl_a, prs_a, rel_a, lng_a, rpt_a, lvl_b, prs_b, rel_b, lng_b, rpt_b}) begin
      fails++;
      $display("FAIL %s got a=%b b=%b want 0", name,
               {lvl_a, prs_a, rel_a, lng_a, rpt_a}, {lvl_b, prs_b, rel_b, lng_b, rpt_b});
    end
  endtask

  initial begin : stim
    logic [CH-1:0] nb;
    int            run [CH];
    int            r;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_state");

    hold(2'b10, 45);                        // clean press, long + repeats
    hold(2'b11, 20);
    hold(2'b10, 3);                         // glitch
    hold(2'b11, 10);
    hold(2'b10, 1); hold(2'b11, 1);         // bounce then settle
    hold(2'b10, 1); hold(2'b11, 1);
    hold(2'b10, 30);
    hold(2'b11, 15);
    hold(2'b10, 15);                        // short hold
    hold(2'b11, 15);
    hold(2'b00, 12);                        // simultaneous press
    hold(2'b10, 30);                        // release ch1 only
    hold(2'b11, 15);

    hold(2'b10, 35);                        // reset while ch0 is in LONG
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_hold");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    hold(2'b10, 35);
    hold(2'b11, 15);

    nb = '1;
    for (int ch = 0; ch < CH; ch++) run[ch] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (run[ch] == 0) begin
          nb[ch] = ~nb[ch];
          r = $urandom_range(0, 9);
          if (r < 3)      run[ch] = $urandom_range(1, 3);
          else if (r < 6) run[ch] = $urandom_range(4, 9);
          else            run[ch] = $urandom_range(10, 60);
        end
        run[ch]--;
      end
      hold(nb, 1);
    end
    hold('1, 30);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
